e203_csr_wr_sched: RTL
======================

Name: e203_csr_wr_sched

Overview:
- Two-requester scheduler for the e203 machine-mode trap CSRs (mtvec, mscratch).
- Arbitrates between the EXU commit path and the debug module, then serialises each access through a 3-state FSM.
- Writes to mtvec happen only when address-select AND write-enable AND not-locked are all true; there is no OR-path.
- Sits between the EXU/debug CSR request ports and the trap-vector logic that consumes mtvec.

Parameters:
- XLEN, 32, data width of CSRs and request data.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- ADDR_MTVEC, 12'h305, CSR address of mtvec.
- ADDR_MSCRATCH, 12'h340, CSR address of mscratch.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- exu_req_valid  in  1  EXU request valid
- exu_req_ready  out  1  EXU request accepted
- exu_req_addr  in  12  EXU CSR address
- exu_req_wen  in  1  EXU write enable (0 = read only)
- exu_req_wdata  in  XLEN  EXU write data
- dbg_req_valid  in  1  debug request valid
- dbg_req_ready  out  1  debug request accepted
- dbg_req_addr  in  12  debug CSR address
- dbg_req_wen  in  1  debug write enable
- dbg_req_wdata  in  XLEN  debug write data
- csr_lock  in  1  blocks EXU writes to mtvec
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_src  out  1  response owner (0 = EXU, 1 = debug)
- rsp_err  out  1  access rejected
- rsp_rdata  out  XLEN  CSR value before the access
- mtvec_r  out  XLEN  current mtvec

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE; rr_ptr = 0 (EXU favoured).
  - mtvec = MTVEC_RST; mscratch = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, rsp_src = 0; both ready outputs = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - ready is driven combinationally to the arbitration winner only.
  - When one side is valid, that side wins. When both are valid, the side pointed to by rr_ptr wins.
  - On handshake: latch src/addr/wen/wdata, set rr_ptr to the loser, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - sel_mtvec = (addr == ADDR_MTVEC); sel_mscr = (addr == ADDR_MSCRATCH).
  - rdata = old value of the selected CSR; 0 if neither is selected.
  - err = !(sel_mtvec | sel_mscr) | (sel_mtvec & wen & csr_lock & src == 0).
  - mtvec_ena = sel_mtvec & wen & !err. mscratch_ena = sel_mscr & wen.
  - Register the response; go to RESP.
- mtvec WARL rules on write:
  - wdata[1:0] in {00, 01}: mode = wdata[1:0]. In {10, 11}: mode keeps its old value.
  - base = wdata[XLEN-1:2].
  - If the resulting mode == 01, base bits [5:2] are forced to 0 (64-byte alignment).
- RESP:
  - rsp_valid = 1, holding src/err/rdata stable until rsp_ready.
  - On rsp_ready: go to IDLE. The next grant occurs at the earliest one cycle later.
- Latency:
  - Handshake in cycle N; CSR updated at the edge ending N+1; rsp_valid high in N+2.
  - Throughput is at most 1 access per 3 cycles.
- csr_lock is sampled in ACCESS only. A change while in IDLE or RESP has no effect on the in-flight access.
- Debug writes ignore csr_lock. Reads are never rejected by csr_lock.
- Reset asserted mid-access: the transaction is dropped, no CSR is updated, and no response is issued.
- A requester may drop valid before it is granted; there is no penalty and rr_ptr is unchanged.

Decomposition:
- Package e203_csr_pkg holds:
  - the CSR address constants;
  - the state enum {IDLE, ACCESS, RESP};
  - the request struct {addr, wen, wdata};
  - the function mtvec_warl(old, wdata) that returns the legalised value.
- Sub-module e203_rr_arb2: 2-way round-robin arbiter (valid in, grant out, pointer update on accept).

Test Plan:
- EXU writes 0x8000_0101 to 0x305, lock = 0: rsp_err = 0, rsp_rdata = 0x0, mtvec_r = 0x8000_0101 → base forced aligned, giving 0x8000_0101 & ~0x3C = 0x8000_0101; rsp_valid occurs 2 cycles after the handshake.
- EXU writes 0x1234_5678 to 0x305 with csr_lock = 1: rsp_err = 1, mtvec unchanged. The same write from debug: rsp_err = 0, mtvec = 0x1234_5678 (mode 00).
- Write 0x0000_0403 (mode 11) while mtvec mode = 01: mode stays 01 and bits [5:2] are cleared, giving mtvec = 0x0000_0401.
- EXU and debug both valid continuously for 4 grants: grant order is EXU, DBG, EXU, DBG, and rsp_src matches each grant.
- Access to 0x300 with wen = 1: rsp_err = 1, rsp_rdata = 0, neither CSR changes. A read of 0x340 after writing 0xDEAD_BEEF returns 0xDEAD_BEEF.
- rsp_ready held low for 5 cycles: rsp fields stay stable and both ready outputs stay 0. rst_n pulsed low during ACCESS: mtvec = MTVEC_RST and rsp_valid = 0.

Source files
------------

// File: rtl/e203_csr_pkg.sv
// Shared types and helpers for the e203 trap-CSR write scheduler.
// Holds CSR addresses, FSM states, the latched request format and mtvec legalisation.
package e203_csr_pkg;

    localparam int          CSR_XLEN      = 32;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } csr_state_e;

    typedef struct packed {
        logic [11:0]         addr;
        logic                wen;
        logic [CSR_XLEN-1:0] wdata;
    } csr_req_t;

    // Reserved modes 10/11 keep the old mode; vectored mode (01) needs 64-byte base alignment.
    function automatic logic [CSR_XLEN-1:0] mtvec_warl(
        input logic [CSR_XLEN-1:0] old_val,
        input logic [CSR_XLEN-1:0] wdata
    );
        logic [CSR_XLEN-1:0] res;
        res = wdata;
        if (wdata[1]) begin
            res[1:0] = old_val[1:0];
        end
        if (res[1:0] == 2'b01) begin
            res[5:2] = 4'b0000;
        end
        return res;
    endfunction

endpackage

// File: rtl/e203_rr_arb2.sv
// Two-way round-robin arbiter: index 0 = EXU, index 1 = debug.
// The pointer names the favoured side and moves to the loser on every accept.
module e203_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr_q)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/e203_csr_wr_sched.sv
// Arbitrates EXU/debug CSR requests and serialises each one through IDLE -> ACCESS -> RESP,
// owning the mtvec and mscratch registers.
module e203_csr_wr_sched
    import e203_csr_pkg::*;
#(
    parameter int          XLEN          = 32,
    parameter logic [31:0] MTVEC_RST     = 32'h0000_0000,
    parameter logic [11:0] ADDR_MTVEC    = CSR_MTVEC,
    parameter logic [11:0] ADDR_MSCRATCH = CSR_MSCRATCH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exu_req_valid,
    output logic            exu_req_ready,
    input  logic [11:0]     exu_req_addr,
    input  logic            exu_req_wen,
    input  logic [XLEN-1:0] exu_req_wdata,
    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic [11:0]     dbg_req_addr,
    input  logic            dbg_req_wen,
    input  logic [XLEN-1:0] dbg_req_wdata,
    input  logic            csr_lock,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_src,
    output logic            rsp_err,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [XLEN-1:0] mtvec_r
);

    csr_state_e      state_q, state_d;
    csr_req_t        req_q, req_d;
    logic            src_q, src_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscr_q, mscr_d;
    logic            rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

    logic       idle;
    logic [1:0] arb_req;
    logic [1:0] gnt;
    logic       accept;
    logic       sel_mtvec;
    logic       sel_mscr;
    logic       acc_err;

    // Requests are only visible to the arbiter while idle and out of reset, so ready is never
    // raised during ACCESS/RESP and the pointer cannot move on a dropped request.
    assign idle    = (state_q == ST_IDLE) && rst_n;
    assign arb_req = {dbg_req_valid, exu_req_valid} & {2{idle}};
    assign accept  = |gnt;

    e203_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (arb_req),
        .accept (accept),
        .gnt    (gnt)
    );

    assign exu_req_ready = gnt[0];
    assign dbg_req_ready = gnt[1];

    assign sel_mtvec = (req_q.addr == ADDR_MTVEC);
    assign sel_mscr  = (req_q.addr == ADDR_MSCRATCH);
    // Only the EXU is subject to the lock; debug writes and all reads pass.
    assign acc_err   = !(sel_mtvec || sel_mscr) ||
                       (sel_mtvec && req_q.wen && csr_lock && !src_q);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        src_d       = src_q;
        mtvec_d     = mtvec_q;
        mscr_d      = mscr_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    src_d = gnt[1];
                    if (gnt[1]) begin
                        req_d = '{addr: dbg_req_addr, wen: dbg_req_wen, wdata: dbg_req_wdata};
                    end else begin
                        req_d = '{addr: exu_req_addr, wen: exu_req_wen, wdata: exu_req_wdata};
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rsp_err_d   = acc_err;
                rsp_rdata_d = sel_mtvec ? mtvec_q : (sel_mscr ? mscr_q : '0);
                if (sel_mtvec && req_q.wen && !acc_err) begin
                    mtvec_d = mtvec_warl(mtvec_q, req_q.wdata);
                end
                if (sel_mscr && req_q.wen) begin
                    mscr_d = req_q.wdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            src_q       <= 1'b0;
            mtvec_q     <= MTVEC_RST;
            mscr_q      <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            src_q       <= src_d;
            mtvec_q     <= mtvec_d;
            mscr_q      <= mscr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_src   = src_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mtvec_r   = mtvec_q;

endmodule
